seq_detector_prog: RTL
======================

Name: seq_detector_prog

Overview:
- Runtime-programmable serial sequence detector. It is the parametrised successor to the fixed "101" detector family.
- Pattern (1..MAX_LEN bits), pattern length, overlap/non-overlap mode and Moore/Mealy output timing are all configuration inputs, latched on a load strobe.
- Adds a data-valid qualifier and a saturating match counter.
- Sits between a serial bit source and control logic that needs match pulses or statistics.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, $clog2(MAX_LEN+1), width of length fields.
- CNT_W, 8, width of match counter.
- DEF_PATTERN, 'b101, pattern active after reset (right-aligned).
- DEF_LEN, 3, length active after reset.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- data  input  1  serial data bit
- valid  input  1  data is a real beat this cycle
- cfg_load  input  1  one-cycle strobe: latch cfg_* into active config
- cfg_pattern  input  MAX_LEN  pattern, right-aligned; bit[len-1] is received first, bit[0] last
- cfg_len  input  LEN_W  pattern length
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping
- cfg_moore  input  1  1 = Moore (registered) output, 0 = Mealy (combinational) output
- detected  output  1  match pulse
- match_count  output  CNT_W  saturating count of matches since reset/load

Behaviour:
- Reset (rst=1 at posedge):
  - Active config = DEF_PATTERN / DEF_LEN / overlap=1 / moore=1.
  - hist=0, fill=0, moore_q=0, match_count=0.
  - detected=0 in the cycle after reset; the Mealy path is also gated to 0 while rst=1.
- State registers:
  - hist[MAX_LEN-1:0]: shift history.
  - fill: beats accumulated toward the current match, 0..MAX_LEN, saturating.
  - Active config registers.
  - moore_q.
- Beat accepted: valid=1 and cfg_load=0 and rst=0.
  - hist <= {hist[MAX_LEN-2:0], data}.
  - fill <= min(fill+1, MAX_LEN).
- Candidate (combinational):
  - cand = beat accepted AND len!=0 AND fill+1 >= len AND lower len bits of {hist[MAX_LEN-2:0], data} == pattern[len-1:0].
  - The compare is masked above len.
- Mealy (moore=0): detected = cand, same cycle as the final bit. Latency 0.
- Moore (moore=1): moore_q <= cand each clock; detected = moore_q. The pulse is one cycle, one clock after the final bit, and is independent of valid in that cycle.
- Overlap=1: fill is unaffected by a match, so a suffix of the match may start the next one. "101" on 10101 gives 2 matches.
- Overlap=0: on cand, fill <= 0. The next match needs len fresh beats. "101" on 10101 gives 1 match; 101101 gives 2.
- valid=0: hist, fill and counter hold; no candidate. A pending Moore pulse still emits.
- match_count increments on cand and saturates at all-ones, with no wrap.
- cfg_load=1:
  - Active config <= cfg_*, with cfg_len clamped to MAX_LEN if larger.
  - fill <= 0, moore_q <= 0, match_count <= 0.
  - Any beat in the same cycle is discarded: not shifted, not matched.
  - detected=0 that cycle in both modes.
- cfg_len=0: detector disabled; detected stays 0 and the counter holds.
- cfg_len=1: a match on every beat equal to pattern[0]. Non-overlap behaves identically to overlap.
- rst has priority over cfg_load; cfg_load has priority over valid.
- Reset mid-pattern: partial history is discarded and fill restarts from 0.
- cfg_* changes are ignored unless cfg_load=1.

Decomposition:
- Package seq_det_pkg:
  - Default constants DEF_PATTERN, DEF_LEN.
  - LEN_W derivation function.
  - typedef cfg_t struct {pattern, len, overlap, moore} for the active-config register.
- One sub-module: seq_match_cmp, a combinational masked compare. Inputs: window, pattern, len, fill. Output: hit.
- Everything else is in the top level.

Test Plan:
1. Legacy equivalence: after reset (101, overlap, Moore), stream 0,1,0,1,0,1 valid every cycle.
   - detected high one cycle after the 4th and 6th beats.
   - match_count=2.
2. Non-overlap Mealy: load len=3, pattern 101, overlap=0, moore=0; stream 1,0,1,0,1,1,0,1.
   - detected same cycle as beats 3 and 8 only.
   - match_count=2.
3. Long pattern with valid gaps: load MAX_LEN=8, pattern 8'b11010011, overlap=1, Moore; send the 8 bits with valid deasserted for 3 random cycles in between.
   - Exactly one pulse, 1 clock after the 8th valid beat.
4. Config boundaries:
   - len=0: 20 random beats give detected=0 and count=0.
   - len=1, pattern 1, stream 1,1,0,1: 3 pulses.
   - cfg_len=15 clamps to 8.
5. Load/reset collisions:
   - cfg_load with valid=1 data=1 mid-match: beat discarded, count=0, no pulse.
   - rst asserted after "10" then stream 1: no detection.
6. Saturation: CNT_W=2; overlap pattern 11, stream 6 ones (5 matches) → match_count stays 3.

Source files
------------

// File: rtl/seq_det_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_det_pkg
//  Description : Shared constants, helpers and the active-configuration record
//                for the programmable serial sequence detector.
//  Revision    : 1.0 - initial release
// ============================================================================
package seq_det_pkg;

    // Capacity of the configuration record. The detector's MAX_LEN must be
    // strictly below PAT_LIMIT and its length field must fit in LEN_LIMIT_W.
    localparam int unsigned PAT_LIMIT   = 64;
    localparam int unsigned LEN_LIMIT_W = 8;

    // Configuration active after reset: the classic "101" detector.
    localparam logic [PAT_LIMIT-1:0] DEF_PATTERN = 64'b101;
    localparam int unsigned          DEF_LEN     = 3;

    // Width needed to hold a length in the range 0..max_len inclusive.
    function automatic int unsigned len_width(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

    // Active configuration; pattern and len are zero-extended into the
    // capacity fields, only the low MAX_LEN / LEN_W bits are meaningful.
    typedef struct packed {
        logic [PAT_LIMIT-1:0]   pattern;
        logic [LEN_LIMIT_W-1:0] len;
        logic                   overlap;
        logic                   moore;
    } cfg_t;

endpackage
`default_nettype wire

// File: rtl/seq_match_cmp.sv
`default_nettype none
// ============================================================================
//  Module      : seq_match_cmp
//  Description : Combinational masked compare of the shift window against the
//                programmed pattern. Only the low len bits take part, and a
//                hit additionally needs enough accumulated beats.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_match_cmp #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic [MAX_LEN-1:0] window,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [LEN_W-1:0]   len,
    input  logic [LEN_W-1:0]   fill,
    output logic               hit
);

    logic [MAX_LEN-1:0] w_mask;
    logic               w_enough;
    logic               w_equal;

    // Bit i takes part in the compare only when it lies below len.
    for (genvar i = 0; i < MAX_LEN; i++) begin : g_mask
        assign w_mask[i] = (len > LEN_W'(i));
    end

    // The window includes the current beat, hence fill+1.
    assign w_enough = (({1'b0, fill} + 1'b1) >= {1'b0, len});
    assign w_equal  = (((window ^ pattern) & w_mask) == '0);
    assign hit      = (len != '0) && w_enough && w_equal;

endmodule
`default_nettype wire

// File: rtl/seq_detector_prog.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector_prog
//  Description : Runtime-programmable serial sequence detector with
//                overlap/non-overlap and Moore/Mealy modes, a data-valid
//                qualifier and a saturating match counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 LEN_W       = seq_det_pkg::len_width(MAX_LEN),
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = seq_det_pkg::DEF_PATTERN[MAX_LEN-1:0],
    parameter int unsigned        DEF_LEN     = seq_det_pkg::DEF_LEN
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               data,
    input  logic               valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cfg_moore,
    output logic               detected,
    output logic [CNT_W-1:0]   match_count
);

    import seq_det_pkg::*;

    cfg_t               cfg_q,   cfg_d;
    logic [MAX_LEN-1:0] hist_q,  hist_d;
    logic [LEN_W-1:0]   fill_q,  fill_d;
    logic               moore_q, moore_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [MAX_LEN-1:0] w_window;
    logic [MAX_LEN-1:0] w_act_pattern;
    logic [LEN_W-1:0]   w_act_len;
    logic [LEN_W-1:0]   w_len_clamped;
    logic               w_beat;
    logic               w_hit;
    logic               w_cand;
    logic               unused_cfg_hi;

    assign w_act_pattern = cfg_q.pattern[MAX_LEN-1:0];
    assign w_act_len     = cfg_q.len[LEN_W-1:0];
    // Capacity bits above MAX_LEN / LEN_W are always zero.
    assign unused_cfg_hi = ^{cfg_q.pattern[PAT_LIMIT-1:MAX_LEN],
                             cfg_q.len[LEN_LIMIT_W-1:LEN_W]};

    // A load takes the whole cycle: any beat alongside it is dropped.
    assign w_beat   = valid & ~cfg_load & ~rst;
    assign w_window = {hist_q[MAX_LEN-2:0], data};

    assign w_len_clamped = (cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : cfg_len;

    seq_match_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .window  (w_window),
        .pattern (w_act_pattern),
        .len     (w_act_len),
        .fill    (fill_q),
        .hit     (w_hit)
    );

    assign w_cand = w_beat & w_hit;

    // Output select: Moore shows last cycle's candidate, Mealy the current one.
    assign detected    = ~cfg_load & (cfg_q.moore ? moore_q : w_cand);
    assign match_count = cnt_q;

    // Next-state: load clears match progress, beats shift and count.
    always_comb begin
        cfg_d   = cfg_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        moore_d = 1'b0;
        cnt_d   = cnt_q;
        if (cfg_load) begin
            cfg_d.pattern                = '0;
            cfg_d.pattern[MAX_LEN-1:0]   = cfg_pattern;
            cfg_d.len                    = '0;
            cfg_d.len[LEN_W-1:0]         = w_len_clamped;
            cfg_d.overlap                = cfg_overlap;
            cfg_d.moore                  = cfg_moore;
            fill_d                       = '0;
            cnt_d                        = '0;
        end else begin
            moore_d = w_cand;
            if (w_beat) begin
                hist_d = w_window;
                if (fill_q != LEN_W'(MAX_LEN)) begin
                    fill_d = fill_q + 1'b1;
                end
            end
            if (w_cand) begin
                // Non-overlap: the next match must be built from fresh beats.
                if (!cfg_q.overlap) begin
                    fill_d = '0;
                end
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    // State registers with synchronous reset to the default configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q.pattern <= PAT_LIMIT'(DEF_PATTERN);
            cfg_q.len     <= LEN_LIMIT_W'(DEF_LEN);
            cfg_q.overlap <= 1'b1;
            cfg_q.moore   <= 1'b1;
            hist_q        <= '0;
            fill_q        <= '0;
            moore_q       <= 1'b0;
            cnt_q         <= '0;
        end else begin
            cfg_q   <= cfg_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            moore_q <= moore_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire
